// File: rtl/cross_bar_resp_if.sv
// Bank-side and channel-side response buses of the mcash response crossbar.
// master = environment (banks + channels), slave = the crossbar itself.
interface cross_bar_resp_if #(
    parameter int DATA_W = 128
);
    logic [3:0]          bank_resp_valid_i;
    logic [3:0]          bank_resp_allowIn_o;
    logic [7:0]          bank_resp_ch_id_i;
    logic [7:0]          bank_resp_opcode_i;
    logic [111:0]        bank_resp_addr_i;
    logic [4*DATA_W-1:0] bank_resp_data_i;

    logic [2:0]          ch_resp_valid_o;
    logic [2:0]          ch_resp_allowIn_i;
    logic [5:0]          ch_resp_bank_id_o;
    logic [5:0]          ch_resp_opcode_o;
    logic [83:0]         ch_resp_addr_o;
    logic [3*DATA_W-1:0] ch_resp_data_o;

    logic                err_o;

    modport master (
        output bank_resp_valid_i, bank_resp_ch_id_i, bank_resp_opcode_i,
               bank_resp_addr_i, bank_resp_data_i, ch_resp_allowIn_i,
        input  bank_resp_allowIn_o, ch_resp_valid_o, ch_resp_bank_id_o,
               ch_resp_opcode_o, ch_resp_addr_o, ch_resp_data_o, err_o
    );

    modport slave (
        input  bank_resp_valid_i, bank_resp_ch_id_i, bank_resp_opcode_i,
               bank_resp_addr_i, bank_resp_data_i, ch_resp_allowIn_i,
        output bank_resp_allowIn_o, ch_resp_valid_o, ch_resp_bank_id_o,
               ch_resp_opcode_o, ch_resp_addr_o, ch_resp_data_o, err_o
    );
endinterface

// File: rtl/cross_bar_resp.sv
// Response crossbar: 4 bank FIFOs feeding 3 channels through per-channel round-robin arbiters.
// Optional same-cycle FIFO bypass for empty banks is enabled with `define XBAR_RESP_BYPASS_EN.
module cross_bar_resp #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    cross_bar_resp_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 32 + DATA_W;

    typedef logic [PW:0] cnt_t;
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    typedef enum logic {
        ARB_OPEN,
        ARB_HELD
    } arb_state_t;

    // Entry layout: {ch_id[1:0], opcode[1:0], addr[27:0], data}
    logic [EW-1:0] mem        [4][DEPTH];
    logic [PW-1:0] rd_ptr     [4];
    logic [PW-1:0] wr_ptr     [4];
    cnt_t          count      [4];
    logic [EW-1:0] in_entry   [4];
    logic [EW-1:0] head_entry [4];
    logic [EW-1:0] eff_entry  [4];
    logic [3:0]    eff_valid;
    logic [3:0]    not_empty;
    logic [3:0]    can_push;
    logic [3:0]    illegal_head;
    logic [3:0]    hs_pop;
    logic [3:0]    fifo_pop;
    logic [3:0]    fifo_push;

    logic [1:0]    rr_ptr        [3];
    logic [1:0]    lock_bank     [3];
    arb_state_t    arb_state     [3];
    arb_state_t    arb_state_nxt [3];
    logic [3:0]    req           [3];
    logic [1:0]    gnt           [3];
    logic [2:0]    gnt_valid;
    logic [2:0]    hs;
    logic          err_q;

    // Per-bank view of what can be offered to the channels this cycle.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            in_entry[b]     = {bus.bank_resp_ch_id_i[2*b +: 2], bus.bank_resp_opcode_i[2*b +: 2],
                               bus.bank_resp_addr_i[28*b +: 28], bus.bank_resp_data_i[DATA_W*b +: DATA_W]};
            head_entry[b]   = mem[b][rd_ptr[b]];
            not_empty[b]    = (count[b] != '0);
            can_push[b]     = (count[b] != FULL_CNT);
            illegal_head[b] = not_empty[b] && (head_entry[b][EW-1 -: 2] == 2'd3);
`ifdef XBAR_RESP_BYPASS_EN
            eff_entry[b]    = not_empty[b] ? head_entry[b] : in_entry[b];
            eff_valid[b]    = not_empty[b] ? !illegal_head[b]
                                           : (bus.bank_resp_valid_i[b] && (in_entry[b][EW-1 -: 2] != 2'd3));
`else
            eff_entry[b]    = head_entry[b];
            eff_valid[b]    = not_empty[b] && !illegal_head[b];
`endif
        end
    end

    // A held channel keeps its previous grant; an open one searches upward from rr_ptr.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < 4; b++) begin
                req[c][b] = eff_valid[b] && (eff_entry[b][EW-1 -: 2] == 2'(c));
            end
            gnt_valid[c] = |req[c];
            gnt[c]       = lock_bank[c];
            if (arb_state[c] == ARB_OPEN) begin
                gnt[c] = rr_ptr[c];
                for (int k = 3; k >= 0; k--) begin
                    if (req[c][2'(rr_ptr[c] + 2'(k))]) begin
                        gnt[c] = 2'(rr_ptr[c] + 2'(k));
                    end
                end
            end
            hs[c]            = gnt_valid[c] && bus.ch_resp_allowIn_i[c];
            arb_state_nxt[c] = (gnt_valid[c] && !bus.ch_resp_allowIn_i[c]) ? ARB_HELD : ARB_OPEN;
        end
    end

    // Illegal heads drain on their own; a bypassed response is consumed without a write.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            hs_pop[b] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (hs[c] && (gnt[c] == 2'(b))) begin
                    hs_pop[b] = 1'b1;
                end
            end
            fifo_pop[b]  = not_empty[b] && (hs_pop[b] || illegal_head[b]);
            fifo_push[b] = bus.bank_resp_valid_i[b] && can_push[b];
`ifdef XBAR_RESP_BYPASS_EN
            if (!not_empty[b] && hs_pop[b]) begin
                fifo_push[b] = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        bus.ch_resp_valid_o     = '0;
        bus.ch_resp_bank_id_o   = '0;
        bus.ch_resp_opcode_o    = '0;
        bus.ch_resp_addr_o      = '0;
        bus.ch_resp_data_o      = '0;
        bus.bank_resp_allowIn_o = can_push;
        bus.err_o               = err_q;
        for (int c = 0; c < 3; c++) begin
            bus.ch_resp_valid_o[c] = gnt_valid[c];
            if (gnt_valid[c]) begin
                bus.ch_resp_bank_id_o[2*c +: 2]       = gnt[c];
                bus.ch_resp_opcode_o[2*c +: 2]        = eff_entry[gnt[c]][EW-3 -: 2];
                bus.ch_resp_addr_o[28*c +: 28]        = eff_entry[gnt[c]][EW-5 -: 28];
                bus.ch_resp_data_o[DATA_W*c +: DATA_W] = eff_entry[gnt[c]][DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int b = 0; b < 4; b++) begin
                rd_ptr[b] <= '0;
                wr_ptr[b] <= '0;
                count[b]  <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                rr_ptr[c]    <= '0;
                lock_bank[c] <= '0;
                arb_state[c] <= ARB_OPEN;
            end
            err_q <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (fifo_push[b]) wr_ptr[b] <= wr_ptr[b] + 1'b1;
                if (fifo_pop[b])  rd_ptr[b] <= rd_ptr[b] + 1'b1;
                count[b] <= count[b] + cnt_t'(fifo_push[b]) - cnt_t'(fifo_pop[b]);
            end
            for (int c = 0; c < 3; c++) begin
                arb_state[c] <= arb_state_nxt[c];
                lock_bank[c] <= gnt[c];
                if (hs[c]) rr_ptr[c] <= gnt[c] + 2'd1;
            end
            err_q <= err_q | (|illegal_head);
        end
    end

    // Storage needs no reset: only entries below count are ever presented.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (fifo_push[b]) mem[b][wr_ptr[b]] <= in_entry[b];
        end
    end
endmodule

// File: tb/tb_cross_bar_resp.sv
// Directed self-checking bench for cross_bar_resp in its default build (no bypass).
module tb_cross_bar_resp;
    logic clk_i;
    logic rst_i;
    int   n_cmp;
    int   n_err;

    cross_bar_resp_if #(.DATA_W(128)) bus ();

    cross_bar_resp #(.DATA_W(128), .DEPTH(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input int b, input logic v, input logic [1:0] ch,
                                 input logic [1:0] op, input logic [27:0] addr, input logic [127:0] data);
        bus.bank_resp_valid_i[b]            = v;
        bus.bank_resp_ch_id_i[2*b +: 2]     = ch;
        bus.bank_resp_opcode_i[2*b +: 2]    = op;
        bus.bank_resp_addr_i[28*b +: 28]    = addr;
        bus.bank_resp_data_i[128*b +: 128]  = data;
    endtask

    task automatic clear_banks();
        bus.bank_resp_valid_i  = '0;
        bus.bank_resp_ch_id_i  = '0;
        bus.bank_resp_opcode_i = '0;
        bus.bank_resp_addr_i   = '0;
        bus.bank_resp_data_i   = '0;
    endtask

    // Advance past one rising edge and settle at the following falling edge.
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0] rr_order [6];
        n_cmp = 0;
        n_err = 0;
        rst_i = 1'b0;
        clear_banks();
        bus.ch_resp_allowIn_i = '0;
        step();
        step();
        rst_i = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_valid",   bus.ch_resp_valid_o, 3'b000);
        checkOutput("rst_allowIn", bus.bank_resp_allowIn_o, 4'hF);
        checkOutput("rst_err",     bus.err_o, 1'b0);
        checkOutput("rst_data",    bus.ch_resp_data_o[127:0], 128'h0);

        $display("[TB] single response bank2 -> ch1");
        bus.ch_resp_allowIn_i = 3'b010;
        applyStimulus(2, 1'b1, 2'd1, 2'd2, 28'h0000ABC, 128'h1234);
        #1;
        checkOutput("single_n_valid", bus.ch_resp_valid_o, 3'b000);
        step();
        clear_banks();
        #1;
        checkOutput("single_valid",   bus.ch_resp_valid_o, 3'b010);
        checkOutput("single_bank_id", bus.ch_resp_bank_id_o[3:2], 2'd2);
        checkOutput("single_opcode",  bus.ch_resp_opcode_o[3:2], 2'd2);
        checkOutput("single_addr",    bus.ch_resp_addr_o[55:28], 28'h0000ABC);
        checkOutput("single_data",    bus.ch_resp_data_o[255:128], 128'h1234);
        checkOutput("single_ch0_id",  bus.ch_resp_bank_id_o[1:0], 2'd0);
        step();
        checkOutput("single_empty_valid", bus.ch_resp_valid_o, 3'b000);
        checkOutput("single_empty_allow", bus.bank_resp_allowIn_o, 4'hF);

        $display("[TB] round robin on ch0");
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
        bus.ch_resp_allowIn_i = 3'b001;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(b, 1'b1, 2'd0, 2'd1, 28'(b), 128'hA0 + 128'(b));
        end
        for (int i = 0; i < 6; i++) begin
            step();
            clear_banks();
            if (i == 3) begin
                applyStimulus(1, 1'b1, 2'd0, 2'd1, 28'h11, 128'hA1);
                applyStimulus(3, 1'b1, 2'd0, 2'd1, 28'h13, 128'hA3);
            end
            #1;
            checkOutput($sformatf("rr_valid_%0d", i), bus.ch_resp_valid_o, 3'b001);
            checkOutput($sformatf("rr_bank_%0d", i),  bus.ch_resp_bank_id_o[1:0], rr_order[i]);
            checkOutput($sformatf("rr_data_%0d", i),  bus.ch_resp_data_o[127:0], 128'hA0 + 128'(rr_order[i]));
        end
        step();
        checkOutput("rr_drained", bus.ch_resp_valid_o, 3'b000);

        $display("[TB] backpressure lock on ch2");
        bus.ch_resp_allowIn_i = 3'b000;
        applyStimulus(3, 1'b1, 2'd2, 2'd3, 28'h33, 128'hB3);
        for (int i = 1; i <= 6; i++) begin
            step();
            clear_banks();
            if (i == 1) applyStimulus(0, 1'b1, 2'd2, 2'd0, 28'h30, 128'hB0);
            if (i == 6) bus.ch_resp_allowIn_i = 3'b100;
            #1;
            checkOutput($sformatf("lock_bank_%0d", i), bus.ch_resp_bank_id_o[5:4], 2'd3);
            checkOutput($sformatf("lock_addr_%0d", i), bus.ch_resp_addr_o[83:56], 28'h33);
            checkOutput($sformatf("lock_data_%0d", i), bus.ch_resp_data_o[383:256], 128'hB3);
        end
        step();
        checkOutput("lock_next_bank", bus.ch_resp_bank_id_o[5:4], 2'd0);
        checkOutput("lock_next_data", bus.ch_resp_data_o[383:256], 128'hB0);
        step();
        checkOutput("lock_drained", bus.ch_resp_valid_o, 3'b000);
        bus.ch_resp_allowIn_i = 3'b000;

        $display("[TB] fifo full on bank1");
        applyStimulus(1, 1'b1, 2'd0, 2'd0, 28'h41, 128'hC1);
        step();
        applyStimulus(1, 1'b1, 2'd0, 2'd0, 28'h42, 128'hC2);
        #1;
        checkOutput("full_one_allow", bus.bank_resp_allowIn_o[1], 1'b1);
        step();
        applyStimulus(1, 1'b1, 2'd0, 2'd0, 28'h43, 128'hC3);
        #1;
        checkOutput("full_allow", bus.bank_resp_allowIn_o[1], 1'b0);
        step();
        clear_banks();
        bus.ch_resp_allowIn_i = 3'b001;
        #1;
        checkOutput("full_still_allow", bus.bank_resp_allowIn_o[1], 1'b0);
        checkOutput("full_first_bank",  bus.ch_resp_bank_id_o[1:0], 2'd1);
        checkOutput("full_first_data",  bus.ch_resp_data_o[127:0], 128'hC1);
        step();
        checkOutput("full_after_pop_allow", bus.bank_resp_allowIn_o[1], 1'b1);
        checkOutput("full_second_data",     bus.ch_resp_data_o[127:0], 128'hC2);
        step();
        checkOutput("full_no_third", bus.ch_resp_valid_o, 3'b000);
        checkOutput("full_empty",    bus.bank_resp_allowIn_o, 4'hF);

        $display("[TB] parallel channels");
        bus.ch_resp_allowIn_i = 3'b111;
        applyStimulus(0, 1'b1, 2'd0, 2'd1, 28'h50, 128'hD0);
        applyStimulus(1, 1'b1, 2'd1, 2'd2, 28'h51, 128'hD1);
        applyStimulus(2, 1'b1, 2'd2, 2'd3, 28'h52, 128'hD2);
        step();
        clear_banks();
        #1;
        checkOutput("par_valid",   bus.ch_resp_valid_o, 3'b111);
        checkOutput("par_bank_id", bus.ch_resp_bank_id_o, 6'b100100);
        checkOutput("par_opcode",  bus.ch_resp_opcode_o, 6'b111001);
        checkOutput("par_data1",   bus.ch_resp_data_o[255:128], 128'hD1);
        checkOutput("par_data2",   bus.ch_resp_data_o[383:256], 128'hD2);
        step();
        checkOutput("par_done_valid", bus.ch_resp_valid_o, 3'b000);
        checkOutput("par_done_allow", bus.bank_resp_allowIn_o, 4'hF);

        $display("[TB] illegal channel id");
        applyStimulus(0, 1'b1, 2'd3, 2'd0, 28'h60, 128'hE0);
        step();
        clear_banks();
        #1;
        checkOutput("ill_head_valid", bus.ch_resp_valid_o, 3'b000);
        checkOutput("ill_head_err",   bus.err_o, 1'b0);
        step();
        checkOutput("ill_err",   bus.err_o, 1'b1);
        checkOutput("ill_allow", bus.bank_resp_allowIn_o, 4'hF);
        checkOutput("ill_valid", bus.ch_resp_valid_o, 3'b000);
        step();
        checkOutput("ill_err_sticky", bus.err_o, 1'b1);

        $display("[TB] mid-operation reset");
        bus.ch_resp_allowIn_i = 3'b000;
        applyStimulus(0, 1'b1, 2'd0, 2'd1, 28'h70, 128'hF0);
        applyStimulus(2, 1'b1, 2'd1, 2'd1, 28'h72, 128'hF2);
        step();
        clear_banks();
        #1;
        checkOutput("prerst_valid", bus.ch_resp_valid_o, 3'b011);
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        #1;
        checkOutput("postrst_err",   bus.err_o, 1'b0);
        checkOutput("postrst_valid", bus.ch_resp_valid_o, 3'b000);
        checkOutput("postrst_allow", bus.bank_resp_allowIn_o, 4'hF);
        bus.ch_resp_allowIn_i = 3'b111;
        step();
        checkOutput("postrst_quiet", bus.ch_resp_valid_o, 3'b000);
        checkOutput("postrst_data",  bus.ch_resp_data_o[127:0], 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cross_bar_resp.md
Name: cross_bar_resp

Overview:
- Response-direction crossbar of the mcash cache. It returns completed requests from the 4 bank HTUs to the 3 requesting channels.
- Each bank response carries the ch_id that the request crossbar attached to it.
- Each bank has a small response FIFO. Each channel has a 4-way round-robin arbiter over the banks whose FIFO head targets that channel.
- Valid/allowIn handshake on both sides.

Parameters:
- DATA_W, 128, response data width per bank and per channel.
- DEPTH, 2, entries per bank response FIFO (power of 2, >= 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-low reset.
- bank_resp_valid_i  in  4  bit b: bank b presents a response.
- bank_resp_allowIn_o  out  4  bit b: bank b FIFO can accept.
- bank_resp_ch_id_i  in  8  [2b+1:2b] destination channel of bank b.
- bank_resp_opcode_i  in  8  [2b+1:2b] opcode echoed from the request.
- bank_resp_addr_i  in  112  [28b+27:28b] line address [31:4] of bank b.
- bank_resp_data_i  in  4*DATA_W  data of bank b.
- ch_resp_valid_o  out  3  bit c: response available to channel c.
- ch_resp_allowIn_i  in  3  bit c: channel c accepts.
- ch_resp_bank_id_o  out  6  [2c+1:2c] source bank of the response.
- ch_resp_opcode_o  out  6  opcode to channel c.
- ch_resp_addr_o  out  84  [28c+27:28c] address to channel c.
- ch_resp_data_o  out  3*DATA_W  data to channel c.
- err_o  out  1  sticky: a response with ch_id==3 was received.

Behaviour:
- Reset (rst_i==0 at posedge):
  - All FIFOs empty; all RR pointers select bank0 as highest priority; all locks cleared; err_o=0.
  - Consequently ch_resp_valid_o=0, bank_resp_allowIn_o=4'hF.
  - ch_resp payload outputs are 0 whenever the corresponding valid is 0.
- Bank side:
  - bank_resp_allowIn_o[b] = count_b != DEPTH, from registered count only; no dependency on pops in the same cycle.
  - Push when valid_i[b] & allowIn_o[b].
  - Full FIFO with a simultaneous pop: allowIn stays 0 that cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, data order preserved.
  - Read/write pointers wrap modulo DEPTH.
- Latency: a response pushed at cycle N is visible on a channel no earlier than N+1 (without the optional feature).
- Channel requests: req_c[b] = (count_b != 0) & (head_ch_id_b == c).
  - A bank head targets exactly one channel, so channels never contend for the same bank.
- Illegal head (ch_id==3):
  - The head is popped unconditionally in the cycle it becomes head and is never presented.
  - err_o sets the following cycle and holds until reset.
- Arbitration per channel:
  - Round-robin search starts at bank (ptr_c) and proceeds upward modulo 4.
  - ch_resp_valid_o[c] = |req_c.
  - The selected bank drives bank_id, opcode, addr and data.
- Lock:
  - If valid_o[c]=1 and allowIn_i[c]=0, the grant for channel c is held next cycle even if a higher-priority bank becomes ready.
  - Payload is stable until the handshake.
  - The lock clears on handshake.
- Handshake:
  - On valid_o[c] & allowIn_i[c], the granted bank FIFO pops.
  - ptr_c becomes (granted+1) mod 4.
  - Non-handshaking channels do not move their pointer.
- All three channels may handshake in the same cycle, on three distinct banks.
- Mid-operation reset discards all FIFO contents and in-flight grants; no response is emitted after reset is released until new pushes arrive.

Optional Feature:
- Macro XBAR_RESP_BYPASS_EN.
- Defined:
  - When bank b's FIFO is empty, an incoming valid response with legal ch_id participates in arbitration in the same cycle.
  - If that response is granted and accepted, it bypasses the FIFO (not written); latency is 0 cycles.
  - Otherwise it is written normally.
  - Bypass never breaks a held lock.
- Undefined: no bypass; minimum latency is 1 cycle.

Test Plan:
- Single response:
  - Stimulus: bank2 sends ch_id=1, addr=28'h0000ABC, data=128'h1234, with ch1 allowIn=1.
  - Required: ch_resp_valid_o=3'b010 at cycle N+1, bank_id=2, payload matches, and the FIFO is empty at N+2 (bypass off).
  - With bypass on: the same response appears at cycle N.
- Round robin:
  - Stimulus: banks 0-3 each hold one response to ch0, with ch0 always ready.
  - Required: grant order 0,1,2,3. Then refill banks 1 and 3: next order 1,3 (ptr starts at 0 after wrapping from 3).
- Backpressure lock:
  - Stimulus: bank3 → ch2 valid with ch2 allowIn=0 for 5 cycles; bank0 → ch2 arrives at cycle 2.
  - Required: bank_id stays 3 and payload is stable for all 5 cycles; bank0's response is delivered after bank3's handshake.
- FIFO full:
  - Stimulus: push 2 responses into bank1 to ch0 with ch0 allowIn=0.
  - Required: bank_resp_allowIn_o[1]=0. A third push is not accepted.
  - Release allowIn: both responses are delivered in order, and allowIn_o[1] returns to 1 the cycle after the first pop.
- Parallel channels: bank0→ch0, bank1→ch1 and bank2→ch2 pushed together with all channels ready; all three handshakes occur in the same cycle.
- Illegal id and reset:
  - ch_id=3 from bank0 is dropped, with no channel valid and err_o=1 one cycle later.
  - Assert rst_i=0 while two FIFOs hold data: err_o=0, all valids 0, and allowIn_o=4'hF after reset.
